// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit in ID: combinational RAW/WAW stall, per-register busy/countdown updated each cycle.
// Optional stall-cycle counter is built only when HAZARD_PERF_EN is defined; otherwise o_stall_cycles reads 0.
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_issue_valid,
    input  logic                          i_issue_reg_write,
    input  logic [REG_ADDR_W-1:0]         i_issue_rd,
    input  logic [LAT_W-1:0]              i_issue_latency,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_issue_srcs,
    input  logic [NUM_SRC-1:0]            i_issue_src_used,
    input  logic                          i_flush,
    input  logic                          i_wb_valid,
    input  logic [REG_ADDR_W-1:0]         i_wb_rd,
    output logic                          o_pc_write,
    output logic                          o_if_id_write,
    output logic                          o_control_mux_nop,
    output logic [NUM_REGS-1:0]           o_busy_mask,
    output logic [31:0]                   o_stall_cycles
);

    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];

    logic [NUM_SRC-1:0]    raw_hit;
    logic                  waw_hit;
    logic                  stall;
    logic                  accept;
    logic [REG_ADDR_W-1:0] src_a;

    // A variable-latency entry being written back this cycle is bypassed, not stalled on.
    always_comb begin
        raw_hit = '0;
        src_a   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_a = i_issue_srcs[k*REG_ADDR_W +: REG_ADDR_W];
            if (i_issue_src_used[k] && (src_a != '0) && busy_q[src_a] && (cnt_q[src_a] != '0)
                && !((cnt_q[src_a] == LAT_MAX) && i_wb_valid && (i_wb_rd == src_a))) begin
                raw_hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        waw_hit = i_issue_reg_write && (i_issue_rd != '0) && busy_q[i_issue_rd]
                  && (cnt_q[i_issue_rd] == LAT_MAX)
                  && !(i_wb_valid && (i_wb_rd == i_issue_rd));
        stall   = i_issue_valid && ((|raw_hit) || waw_hit);
        accept  = i_issue_valid && !stall && !i_flush;
    end

    assign o_pc_write        = ~stall;
    assign o_if_id_write     = ~stall;
    assign o_control_mux_nop = stall | i_flush;
    assign o_busy_mask       = busy_q;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            if (busy_q[r]) begin
                if (cnt_q[r] == '0) begin
                    busy_d[r] = 1'b0;
                end else if (cnt_q[r] == LAT_MAX) begin
                    if (i_wb_valid && (i_wb_rd == REG_ADDR_W'(r))) begin
                        busy_d[r] = 1'b0;
                        cnt_d[r]  = '0;
                    end
                end else begin
                    cnt_d[r] = cnt_q[r] - LAT_W'(1);
                end
            end
            // A new issue to the same register overrides any same-cycle writeback.
            if (accept && i_issue_reg_write && (i_issue_rd == REG_ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = i_issue_latency;
            end
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random issue/writeback traffic against a timeline model.
module tb_hazard_scoreboard;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int LW   = 3;
    localparam int LMAX = 7;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_issue_valid;
    logic              i_issue_reg_write;
    logic [AW-1:0]     i_issue_rd;
    logic [LW-1:0]     i_issue_latency;
    logic [NS*AW-1:0]  i_issue_srcs;
    logic [NS-1:0]     i_issue_src_used;
    logic              i_flush;
    logic              i_wb_valid;
    logic [AW-1:0]     i_wb_rd;
    logic              o_pc_write;
    logic              o_if_id_write;
    logic              o_control_mux_nop;
    logic [NR-1:0]     o_busy_mask;
    logic [31:0]       o_stall_cycles;

    hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_issue_valid     (i_issue_valid),
        .i_issue_reg_write (i_issue_reg_write),
        .i_issue_rd        (i_issue_rd),
        .i_issue_latency   (i_issue_latency),
        .i_issue_srcs      (i_issue_srcs),
        .i_issue_src_used  (i_issue_src_used),
        .i_flush           (i_flush),
        .i_wb_valid        (i_wb_valid),
        .i_wb_rd           (i_wb_rd),
        .o_pc_write        (o_pc_write),
        .o_if_id_write     (o_if_id_write),
        .o_control_mux_nop (o_control_mux_nop),
        .o_busy_mask       (o_busy_mask),
        .o_stall_cycles    (o_stall_cycles)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a fixed-latency write accepted in cycle t keeps the register busy
    // through cycle t+L+1 and blocks readers through cycle t+L. A variable-latency
    // write stays pending until its writeback.
    int          busy_until [NR];
    bit          pend_var   [NR];
    longint      m_stalls;
    int          cyc = 0;

    logic        obs_pc, obs_nop;
    logic [NR-1:0] obs_busy;
    logic [31:0] obs_sc;

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) begin
            busy_until[r] = -1000;
            pend_var[r]   = 1'b0;
        end
        m_stalls = 0;
    endfunction

    function automatic bit m_busy(input int r);
        return (r != 0) && (pend_var[r] || (cyc <= busy_until[r]));
    endfunction

    function automatic bit m_not_ready(input int r);
        return (r != 0) && (pend_var[r] || (cyc < busy_until[r]));
    endfunction

    task automatic step(input bit v, input bit rw, input int rd, input int lat,
                        input int s0, input int s1, input bit [1:0] used,
                        input bit fl, input bit wbv, input int wbrd);
        bit            st;
        bit            raw0, raw1, waw;
        logic [NR-1:0] exp_busy;
        logic [63:0]   exp_sc;
        i_issue_valid     = v;
        i_issue_reg_write = rw;
        i_issue_rd        = AW'(rd);
        i_issue_latency   = LW'(lat);
        i_issue_srcs      = {AW'(s1), AW'(s0)};
        i_issue_src_used  = used;
        i_flush           = fl;
        i_wb_valid        = wbv;
        i_wb_rd           = AW'(wbrd);
        @(negedge i_clk);
        raw0 = used[0] && m_not_ready(s0) && !(pend_var[s0] && wbv && (wbrd == s0));
        raw1 = used[1] && m_not_ready(s1) && !(pend_var[s1] && wbv && (wbrd == s1));
        waw  = rw && (rd != 0) && pend_var[rd] && !(wbv && (wbrd == rd));
        st   = v && (raw0 || raw1 || waw);
        for (int r = 0; r < NR; r++) exp_busy[r] = m_busy(r);
        exp_sc = PERF ? 64'(m_stalls) : 64'd0;
        check_val("pc_write",   64'(o_pc_write),        64'(!st));
        check_val("if_id_write",64'(o_if_id_write),     64'(!st));
        check_val("nop_sel",    64'(o_control_mux_nop), 64'(st || fl));
        check_val("busy_mask",  64'(o_busy_mask),       64'(exp_busy));
        check_val("stall_cnt",  64'(o_stall_cycles),    exp_sc);
        obs_pc   = o_pc_write;
        obs_nop  = o_control_mux_nop;
        obs_busy = o_busy_mask;
        obs_sc   = o_stall_cycles;
        @(posedge i_clk);
        if (st) m_stalls++;
        if (wbv && (wbrd != 0) && pend_var[wbrd]) pend_var[wbrd] = 1'b0;
        if (v && !st && !fl && rw && (rd != 0)) begin
            if (lat == LMAX) begin
                pend_var[rd]   = 1'b1;
                busy_until[rd] = -1000;
            end else begin
                pend_var[rd]   = 1'b0;
                busy_until[rd] = cyc + 1 + lat;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_issue_valid = 0; i_issue_reg_write = 0; i_issue_rd = '0; i_issue_latency = '0;
        i_issue_srcs = '0; i_issue_src_used = '0; i_flush = 0; i_wb_valid = 0; i_wb_rd = '0;
        model_reset();
        #2;
        check_val("rst_pc",   64'(o_pc_write),        64'd1);
        check_val("rst_ifid", 64'(o_if_id_write),     64'd1);
        check_val("rst_nop",  64'(o_control_mux_nop), 64'd0);
        check_val("rst_busy", 64'(o_busy_mask),       64'd0);
        check_val("rst_sc",   64'(o_stall_cycles),    64'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Load-use: exactly one stall cycle.
        step(1, 1, 5, 1, 0, 0, 2'b00, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0);
        check_val("lu_stall_pc",  64'(obs_pc),  64'd0);
        check_val("lu_stall_nop", 64'(obs_nop), 64'd1);
        step(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0);
        check_val("lu_go_pc", 64'(obs_pc), 64'd1);

        // ALU chain and x0 never stall.
        step(1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0);
        step(1, 1, 0, 0, 3, 0, 2'b01, 0, 0, 0);
        check_val("alu_pc", 64'(obs_pc), 64'd1);
        step(1, 1, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        check_val("x0_pc", 64'(obs_pc), 64'd1);

        // Divider: 20 stalls, then same-cycle writeback bypass.
        step(1, 1, 7, LMAX, 0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8, 0, 7, 0, 2'b01, 0, 0, 0);
            check_val("div_stall", 64'(obs_pc), 64'd0);
        end
        step(1, 1, 8, 0, 7, 0, 2'b01, 0, 1, 7);
        check_val("div_bypass", 64'(obs_pc), 64'd1);
        idle();
        check_val("div_clear", 64'(obs_busy[7]), 64'd0);
        check_val("sc_21", 64'(obs_sc), PERF ? 64'd21 : 64'd0);

        // WAW and flush with a dependent instruction.
        step(1, 1, 7, LMAX, 0, 0, 2'b00, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0);
        check_val("waw_stall", 64'(obs_pc), 64'd0);
        step(1, 1, 9, 0, 7, 0, 2'b01, 1, 0, 0);
        check_val("flush_nop", 64'(obs_nop), 64'd1);
        idle();
        check_val("flush_nobusy", 64'(obs_busy[9]), 64'd0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 7);
        idle();

        // Asynchronous reset mid-operation.
        step(1, 1, 5, LMAX, 0, 0, 2'b00, 0, 0, 0);
        i_issue_valid = 0; i_issue_reg_write = 0; i_issue_src_used = '0; i_flush = 0; i_wb_valid = 0;
        #2 i_rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 64'(o_busy_mask), 64'd0);
        check_val("mid_rst_pc",   64'(o_pc_write),  64'd1);
        model_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            int lat;
            lat = ($urandom_range(0, 3) == 0) ? LMAX : int'($urandom_range(0, LMAX - 1));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), int'($urandom_range(0, 7)), lat,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised scoreboard-based hazard unit for the pipelined RISC-V core. It replaces single-load-use stall detection.
- Tracks every in-flight register write with a per-register readiness countdown.
- Supports ALU (0), load (1) and multi-cycle or variable-latency results (divider, external memory).
- Sits in ID and drives the PC write enable, the IF/ID write enable and the control-NOP mux select.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
REG_ADDR_W, 5, register address width; must satisfy 2^REG_ADDR_W >= NUM_REGS.
NUM_SRC, 2, number of source operands checked per issuing instruction.
LAT_W, 3, width of the latency field. The value 2^LAT_W-1 (LAT_MAX) is the sentinel meaning "ready only at writeback".

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_issue_valid  in  1  an instruction in ID requests issue
i_issue_reg_write  in  1  the issuing instruction writes rd
i_issue_rd  in  REG_ADDR_W  destination register
i_issue_latency  in  LAT_W  cycles until the result is forwardable; LAT_MAX = variable latency
i_issue_srcs  in  NUM_SRC*REG_ADDR_W  packed source addresses; src k is at bits [k*REG_ADDR_W +: REG_ADDR_W]
i_issue_src_used  in  NUM_SRC  per-source valid mask
i_flush  in  1  squash the instruction currently in ID
i_wb_valid  in  1  writeback of a variable-latency result this cycle
i_wb_rd  in  REG_ADDR_W  writeback destination
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID pipeline register write enable
o_control_mux_nop  out  1  select NOP control bundle into ID/EX
o_busy_mask  out  NUM_REGS  registered busy bit per register
o_stall_cycles  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
State per register r: busy[r] (1 bit) and cnt[r] (LAT_W bits). busy[0] and cnt[0] are permanently 0.

Reset (async, i_rst=1): all busy and cnt cleared. Resulting outputs:
- o_pc_write=1, o_if_id_write=1, o_control_mux_nop=0
- o_busy_mask=0, o_stall_cycles=0

RAW hazard, combinational. Fires for a source k when all of the following hold:
- i_issue_src_used[k]=1 and src_k != 0
- busy[src_k]=1 and cnt[src_k] != 0
- NOT (cnt[src_k]==LAT_MAX and i_wb_valid and i_wb_rd==src_k); a same-cycle writeback is bypassed.

WAW hazard, combinational: i_issue_reg_write, i_issue_rd != 0, busy[i_issue_rd]=1 and cnt[i_issue_rd]==LAT_MAX, with no same-cycle writeback to that rd.

Stall = i_issue_valid & (any RAW | WAW).
- o_pc_write = o_if_id_write = ~stall
- o_control_mux_nop = stall | i_flush

Issue accepted = i_issue_valid & ~stall & ~i_flush. On accept with i_issue_reg_write and rd != 0, next cycle busy[rd]=1 and cnt[rd]=i_issue_latency.

Per cycle, for every other busy register:
- cnt not in {0, LAT_MAX}: decrement by 1.
- cnt==0: forwardable. It stays busy until the value reaches WB, at which point forwarding covers it; cnt==0 entries clear after one further cycle (busy<=0).
- cnt==LAT_MAX: held until i_wb_valid with i_wb_rd==r, then busy<=0 and cnt<=0.

Simultaneous events:
- An accepted issue to rd in the same cycle as a writeback to rd: issue wins, entry reloaded.
- A writeback to a non-busy or zero register is ignored.
- i_flush with a stall: NOP inserted, no state change from the squashed instruction.

Latency examples:
- Load (latency 1) issued at cycle t: a dependent instruction stalls at t+1 and issues at t+2.
- ALU (latency 0): never stalls a dependent instruction.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: o_stall_cycles increments each cycle stall=1, saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: o_stall_cycles is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset mid-operation: busy[5] set with LAT_MAX, assert i_rst -> o_busy_mask=0 immediately, o_pc_write=1.
- Load-use: issue rd=5 with latency 1, next cycle issue srcs {5,0} used 2'b01 -> exactly one cycle with o_pc_write=0 and o_control_mux_nop=1, then accepted.
- ALU chain: rd=3 latency 0 followed by src 3 -> no stall; src 0 with x0 rd never stalls.
- Divider: rd=7 latency 7 (LAT_MAX), dependent src 7 stalls for 20 cycles. Then i_wb_valid, i_wb_rd=7 -> same-cycle bypass gives o_pc_write=1 that cycle, and busy[7]=0 next cycle.
- WAW and flush: with rd=7 pending LAT_MAX, issue rd=7 latency 0 -> stall. Assert i_flush with a dependent instruction -> o_control_mux_nop=1 and no busy bit is set by it.
- HAZARD_PERF_EN: after the load-use and divider scenarios, o_stall_cycles=21. With the macro undefined it reads 0.
